cap_axi_writer: RTL and testbench

//  Capture write-back stage: drains the capture pixel FIFO (ACLK read side) and writes frames to VRAM over an AXI3/4 write-only master.
//  - Each FIFO entry holds two RGB888 pixels {r1,g1,b1,r0,g0,b0} and becomes one 64-bit beat of two XRGB8888 words.
//  - Issues fixed-length INCR bursts from a latched base address until a full frame is written, then pulses FRMDONE.

---
 rtl/cap_axi_writer.sv | 179 +++++++++++++++++
 tb/tb_cap_axi_writer.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cap_axi_writer.sv
// Capture write-back stage: drains the capture pixel FIFO and writes each frame to VRAM
// as fixed-length AXI INCR bursts, with one burst outstanding at a time.
module cap_axi_writer #(
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_CNT_W = 10,
    parameter int unsigned NB_VGA     = 640 * 480 / 2 / BURST_LEN,
    parameter int unsigned NB_XGA     = 1024 * 768 / 2 / BURST_LEN,
    parameter int unsigned NB_SXGA    = 1280 * 1024 / 2 / BURST_LEN
) (
    input  logic                  ACLK,
    input  logic                  ARST,
    input  logic                  CAPSTART,
    input  logic [31:0]           VRAMADR,
    input  logic [1:0]            RESOL,
    input  logic [47:0]           FIFOOUT,
    input  logic                  FIFOEMPTY,
    input  logic [FIFO_CNT_W-1:0] FIFOCNT,
    output logic                  FIFORD,
    output logic [31:0]           AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [63:0]           WDATA,
    output logic [7:0]            WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic                  BUSY,
    output logic                  FRMDONE,
    output logic                  WRERR
);

    localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    // Wide enough for the largest frame at the shortest legal burst.
    localparam int unsigned CntW = 20;

    localparam logic [BeatW-1:0]      LastBeat   = BeatW'(BURST_LEN - 1);
    localparam logic [FIFO_CNT_W-1:0] BurstCnt   = FIFO_CNT_W'(BURST_LEN);
    localparam logic [31:0]           BurstBytes = 32'(BURST_LEN * 8);

    typedef enum logic [2:0] {StIdle, StWait, StAddr, StData, StResp} state_e;

    state_e           state_q, state_d;
    logic [31:0]      awaddr_q, awaddr_d;
    logic [1:0]       resol_q, resol_d;
    logic [CntW-1:0]  burst_cnt_q, burst_cnt_d;
    logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
    logic             wrerr_q, wrerr_d;
    logic             frmdone_q, frmdone_d;

    logic [CntW-1:0]  nb;
    logic [CntW-1:0]  burst_inc;
    logic             w_fire;
    logic             last_beat;
    logic             frame_end;

    always_comb begin
        case (resol_q)
            2'd0:    nb = CntW'(NB_VGA);
            2'd1:    nb = CntW'(NB_XGA);
            default: nb = CntW'(NB_SXGA);
        endcase
    end

    assign burst_inc = burst_cnt_q + 1'b1;
    assign frame_end = (burst_inc == nb);
    assign last_beat = (beat_cnt_q == LastBeat);
    // An empty FIFO never produces a beat, so it can never pop.
    assign w_fire    = (state_q == StData) && !FIFOEMPTY && WREADY;

    // FSM: state register
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (CAPSTART) state_d = StWait;
            // A full burst must already be buffered so WVALID never starves mid-burst.
            StWait: if (FIFOCNT >= BurstCnt) state_d = StAddr;
            StAddr: if (AWREADY) state_d = StData;
            StData: if (w_fire && last_beat) state_d = StResp;
            StResp: if (BVALID) state_d = frame_end ? StIdle : StWait;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        WLAST   = 1'b0;
        BREADY  = 1'b0;
        BUSY    = 1'b1;
        case (state_q)
            StIdle: BUSY = 1'b0;
            StAddr: AWVALID = 1'b1;
            StData: begin
                WVALID = !FIFOEMPTY;
                WLAST  = last_beat;
            end
            StResp: BREADY = 1'b1;
            default: BUSY = 1'b1;
        endcase
        FIFORD = WVALID && WREADY;
    end

    // Datapath next state
    always_comb begin
        awaddr_d    = awaddr_q;
        resol_d     = resol_q;
        burst_cnt_d = burst_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        wrerr_d     = wrerr_q;
        frmdone_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (CAPSTART) begin
                    awaddr_d    = VRAMADR;
                    resol_d     = RESOL;
                    burst_cnt_d = '0;
                    wrerr_d     = 1'b0;
                end
            end
            StAddr: if (AWREADY) beat_cnt_d = '0;
            StData: if (w_fire) beat_cnt_d = beat_cnt_q + 1'b1;
            StResp: begin
                // Errored bursts are not retried; they still advance the frame.
                if (BVALID) begin
                    wrerr_d     = wrerr_q | (BRESP != 2'b00);
                    awaddr_d    = awaddr_q + BurstBytes;
                    burst_cnt_d = burst_inc;
                    frmdone_d   = frame_end;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            awaddr_q    <= '0;
            resol_q     <= '0;
            burst_cnt_q <= '0;
            beat_cnt_q  <= '0;
            wrerr_q     <= 1'b0;
            frmdone_q   <= 1'b0;
        end else begin
            awaddr_q    <= awaddr_d;
            resol_q     <= resol_d;
            burst_cnt_q <= burst_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            wrerr_q     <= wrerr_d;
            frmdone_q   <= frmdone_d;
        end
    end

    assign AWADDR  = awaddr_q;
    assign AWLEN   = 8'(BURST_LEN - 1);
    assign AWSIZE  = 3'b011;
    assign AWBURST = 2'b01;
    assign WSTRB   = 8'hFF;
    // Two RGB888 pixels become two XRGB8888 words.
    assign WDATA   = {8'h00, FIFOOUT[47:24], 8'h00, FIFOOUT[23:0]};
    assign FRMDONE = frmdone_q;
    assign WRERR   = wrerr_q;

endmodule

// File: tb/tb_cap_axi_writer.sv
// Directed bench for cap_axi_writer: reactive AXI slave and FIFO models, shortened frame
// lengths so complete frames fit in a short run.
module tb_cap_axi_writer;

    localparam int BL = 16;

    logic        ACLK = 1'b0;
    logic        ARST = 1'b1;
    logic        CAPSTART = 1'b0;
    logic [31:0] VRAMADR = '0;
    logic [1:0]  RESOL = '0;
    logic [47:0] FIFOOUT;
    logic        FIFOEMPTY = 1'b0;
    logic [9:0]  FIFOCNT = '0;
    logic        FIFORD;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY = 1'b0;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY = 1'b1;
    logic [1:0]  BRESP = 2'b00;
    logic        BVALID = 1'b0;
    logic        BREADY;
    logic        BUSY;
    logic        FRMDONE;
    logic        WRERR;

    cap_axi_writer #(
        .BURST_LEN (BL),
        .FIFO_CNT_W(10),
        .NB_VGA    (3),
        .NB_XGA    (6),
        .NB_SXGA   (4)
    ) dut (
        .ACLK     (ACLK),
        .ARST     (ARST),
        .CAPSTART (CAPSTART),
        .VRAMADR  (VRAMADR),
        .RESOL    (RESOL),
        .FIFOOUT  (FIFOOUT),
        .FIFOEMPTY(FIFOEMPTY),
        .FIFOCNT  (FIFOCNT),
        .FIFORD   (FIFORD),
        .AWADDR   (AWADDR),
        .AWLEN    (AWLEN),
        .AWSIZE   (AWSIZE),
        .AWBURST  (AWBURST),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WLAST    (WLAST),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .BUSY     (BUSY),
        .FRMDONE  (FRMDONE),
        .WRERR    (WRERR)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    // Slave / FIFO controls, written only by the test tasks.
    int unsigned aw_delay = 0;
    bit          w_toggle = 1'b0;
    int unsigned err_at = 32'hFFFF_FFFF;

    // Observations, written only by the monitor.
    int unsigned aw_cnt = 0, w_cnt = 0, pop_cnt = 0, b_cnt = 0, frm_cnt = 0, frm_b_cnt = 0;
    int unsigned wdata_bad = 0, wlast_bad = 0, hold_bad = 0, pop_bad = 0, aw_drop_bad = 0;
    logic [31:0] aw_log [256];
    int          beat = 0;
    bit          aw_hs = 0, w_hs = 0, wlast_hs = 0, b_hs = 0;
    bit          prev_aw_stall = 0, prev_w_stall = 0;
    logic [63:0] prev_wdata = '0;

    int unsigned pop_idx = 0;
    int unsigned aw_wait = 0;

    function automatic logic [23:0] pix_lo(input int unsigned i);
        return 24'(i * 13 + 5);
    endfunction

    function automatic logic [23:0] pix_hi(input int unsigned i);
        return 24'(i * 13 + 5) ^ 24'hC3A55A;
    endfunction

    assign FIFOOUT = {pix_hi(pop_idx), pix_lo(pop_idx)};

    function automatic int unsigned bad_sum();
        return wdata_bad + wlast_bad + hold_bad + pop_bad + aw_drop_bad;
    endfunction

    // Monitor: sample away from the active edge; handshakes complete at the next posedge.
    always @(negedge ACLK) begin
        aw_hs = 0; w_hs = 0; wlast_hs = 0; b_hs = 0;
        if (ARST) begin
            beat = 0;
            prev_aw_stall = 0;
            prev_w_stall = 0;
        end else begin
            if (prev_aw_stall && !AWVALID) aw_drop_bad++;
            if (prev_w_stall && (!WVALID || WDATA !== prev_wdata)) hold_bad++;
            if (FIFORD !== (WVALID && WREADY)) pop_bad++;
            if (FIFORD) pop_cnt++;
            if (AWVALID && AWREADY) begin
                aw_log[aw_cnt % 256] = AWADDR;
                aw_cnt++;
                aw_hs = 1;
            end
            if (WVALID && WREADY) begin
                if (WDATA !== {8'h00, pix_hi(pop_idx), 8'h00, pix_lo(pop_idx)}) wdata_bad++;
                if (WLAST !== (beat == BL - 1)) wlast_bad++;
                w_cnt++;
                w_hs = 1;
                wlast_hs = (beat == BL - 1);
                beat = (beat == BL - 1) ? 0 : beat + 1;
            end
            if (BVALID && BREADY) begin
                b_cnt++;
                b_hs = 1;
            end
            if (FRMDONE) begin
                frm_cnt++;
                frm_b_cnt = b_cnt;
            end
            prev_aw_stall = AWVALID && !AWREADY;
            prev_w_stall = WVALID && !WREADY;
            prev_wdata = WDATA;
        end
    end

    // AXI slave and FIFO pop model, updated just after the active edge.
    always @(posedge ACLK) begin
        #1;
        if (ARST) begin
            aw_wait = 0;
            AWREADY = 1'b0;
            WREADY = 1'b1;
            BVALID = 1'b0;
            BRESP = 2'b00;
        end else begin
            if (aw_hs) aw_wait = 0;
            else if (prev_aw_stall) aw_wait++;
            AWREADY = (aw_wait >= aw_delay);
            WREADY = w_toggle ? ~WREADY : 1'b1;
            if (b_hs) BVALID = 1'b0;
            if (wlast_hs) begin
                BVALID = 1'b1;
                BRESP = (b_cnt == err_at) ? 2'b10 : 2'b00;
            end
            if (w_hs) pop_idx++;
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] addr, input logic [1:0] res);
        tick();
        CAPSTART = 1'b1;
        VRAMADR = addr;
        RESOL = res;
        tick();
        CAPSTART = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int unsigned f0, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge ACLK);
            if (frm_cnt != f0) begin
                ok = 1;
                break;
            end
        end
        repeat (3) @(negedge ACLK);
    endtask

    task automatic test_reset();
        ARST = 1'b1;
        repeat (3) tick();
        @(negedge ACLK);
        checks++;
        if ({AWVALID, WVALID, WLAST, BREADY, FIFORD, BUSY, FRMDONE, WRERR} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000000",
                     {AWVALID, WVALID, WLAST, BREADY, FIFORD, BUSY, FRMDONE, WRERR});
        end
        checks++;
        if (AWADDR !== 32'h0) begin
            errors++;
            $display("FAIL reset_awaddr got %h want 00000000", AWADDR);
        end
        checks++;
        if ({AWLEN, AWSIZE, AWBURST, WSTRB} !== {8'd15, 3'b011, 2'b01, 8'hFF}) begin
            errors++;
            $display("FAIL axi_constants got %h/%b/%b/%h want 0f/011/01/ff",
                     AWLEN, AWSIZE, AWBURST, WSTRB);
        end
        tick();
        ARST = 1'b0;
        tick();
    endtask

    task automatic test_vga_frame();
        int unsigned a0 = aw_cnt, w0 = w_cnt, p0 = pop_cnt, b0 = b_cnt, f0 = frm_cnt;
        int unsigned bad0 = bad_sum();
        bit ok;
        FIFOCNT = 10'd512;
        start_frame(32'h1000_0000, 2'd0);
        wait_done(3000, f0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL vga_done got timeout want FRMDONE"); end
        checks++;
        if (aw_cnt - a0 != 3) begin
            errors++; $display("FAIL vga_bursts got %0d want 3", aw_cnt - a0);
        end
        checks++;
        if (aw_log[a0 % 256] !== 32'h1000_0000) begin
            errors++; $display("FAIL vga_first_addr got %h want 10000000", aw_log[a0 % 256]);
        end
        checks++;
        if (aw_log[(a0 + 2) % 256] !== 32'h1000_0100) begin
            errors++;
            $display("FAIL vga_last_addr got %h want 10000100", aw_log[(a0 + 2) % 256]);
        end
        checks++;
        if (pop_cnt - p0 != 48 || w_cnt - w0 != 48) begin
            errors++;
            $display("FAIL vga_pops got %0d/%0d want 48/48", pop_cnt - p0, w_cnt - w0);
        end
        checks++;
        if (frm_cnt - f0 != 1 || frm_b_cnt != b0 + 3) begin
            errors++;
            $display("FAIL vga_frmdone got pulses %0d after %0d resp want 1 after 3",
                     frm_cnt - f0, frm_b_cnt - b0);
        end
        checks++;
        if (BUSY !== 1'b0 || WRERR !== 1'b0 || bad_sum() != bad0) begin
            errors++;
            $display("FAIL vga_end got busy %b wrerr %b protocol errs %0d want 0 0 0",
                     BUSY, WRERR, bad_sum() - bad0);
        end
    endtask

    task automatic test_backpressure();
        int unsigned a0 = aw_cnt, w0 = w_cnt, p0 = pop_cnt, f0 = frm_cnt;
        int unsigned bad0 = bad_sum();
        bit ok;
        aw_delay = 3;
        w_toggle = 1'b1;
        start_frame(32'h2000_0000, 2'd0);
        wait_done(4000, f0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_done got timeout want FRMDONE"); end
        checks++;
        if (wdata_bad + hold_bad + wlast_bad + aw_drop_bad + pop_bad != bad0) begin
            errors++;
            $display("FAIL bp_protocol got data %0d hold %0d last %0d awdrop %0d pop %0d want 0",
                     wdata_bad, hold_bad, wlast_bad, aw_drop_bad, pop_bad);
        end
        checks++;
        if (pop_cnt - p0 != 48 || w_cnt - w0 != 48 || aw_cnt - a0 != 3) begin
            errors++;
            $display("FAIL bp_counts got pops %0d beats %0d aw %0d want 48 48 3",
                     pop_cnt - p0, w_cnt - w0, aw_cnt - a0);
        end
        aw_delay = 0;
        w_toggle = 1'b0;
        tick();
    endtask

    task automatic test_fifo_threshold();
        int unsigned a0 = aw_cnt, p0 = pop_cnt, f0 = frm_cnt;
        bit ok;
        FIFOCNT = 10'd15;
        aw_delay = 4;
        start_frame(32'h0800_0000, 2'd0);
        repeat (8) @(negedge ACLK);
        checks++;
        if ({BUSY, AWVALID, FIFORD} !== 3'b100 || pop_cnt != p0) begin
            errors++;
            $display("FAIL thr_wait got busy/awvalid/fiford %b pops %0d want 100 0",
                     {BUSY, AWVALID, FIFORD}, pop_cnt - p0);
        end
        tick();
        FIFOCNT = 10'd16;
        tick();
        tick();
        @(negedge ACLK);
        checks++;
        if (AWVALID !== 1'b1 || AWADDR !== 32'h0800_0000) begin
            errors++;
            $display("FAIL thr_addr got awvalid %b awaddr %h want 1 08000000", AWVALID, AWADDR);
        end
        wait_done(3000, f0, ok);
        checks++;
        if (!ok || aw_cnt - a0 != 3) begin
            errors++; $display("FAIL thr_frame got done %b bursts %0d want 1 3", ok, aw_cnt - a0);
        end
        aw_delay = 0;
        FIFOCNT = 10'd512;
    endtask

    task automatic test_bresp_err();
        int unsigned a0 = aw_cnt, b0 = b_cnt, f0 = frm_cnt;
        bit ok;
        err_at = b_cnt + 4;
        start_frame(32'h0200_0000, 2'd1);
        for (int i = 0; i < 2000 && b_cnt - b0 < 4; i++) @(negedge ACLK);
        @(negedge ACLK);
        checks++;
        if (WRERR !== 1'b0) begin errors++; $display("FAIL err_before got %b want 0", WRERR); end
        for (int i = 0; i < 2000 && b_cnt - b0 < 5; i++) @(negedge ACLK);
        @(negedge ACLK);
        checks++;
        if (WRERR !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", WRERR); end
        wait_done(3000, f0, ok);
        err_at = 32'hFFFF_FFFF;
        checks++;
        if (!ok || b_cnt - b0 != 6 || aw_cnt - a0 != 6) begin
            errors++;
            $display("FAIL err_frame got done %b resp %0d aw %0d want 1 6 6",
                     ok, b_cnt - b0, aw_cnt - a0);
        end
        checks++;
        if (aw_log[(a0 + 5) % 256] !== 32'h0200_0280) begin
            errors++;
            $display("FAIL err_last_addr got %h want 02000280", aw_log[(a0 + 5) % 256]);
        end
        checks++;
        if (WRERR !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", WRERR); end
        f0 = frm_cnt;
        start_frame(32'h0300_0000, 2'd0);
        @(negedge ACLK);
        checks++;
        if (WRERR !== 1'b0 || BUSY !== 1'b1) begin
            errors++; $display("FAIL err_clear got wrerr %b busy %b want 0 1", WRERR, BUSY);
        end
        wait_done(3000, f0, ok);
        checks++;
        if (!ok || WRERR !== 1'b0) begin
            errors++; $display("FAIL err_clean_frame got done %b wrerr %b want 1 0", ok, WRERR);
        end
    endtask

    task automatic test_capstart_ignored();
        int unsigned a0 = aw_cnt, f0 = frm_cnt;
        bit ok;
        start_frame(32'h3000_0000, 2'd0);
        for (int i = 0; i < 500 && aw_cnt == a0; i++) @(negedge ACLK);
        tick();
        CAPSTART = 1'b1;
        VRAMADR = 32'h4000_0000;
        RESOL = 2'd2;
        tick();
        CAPSTART = 1'b0;
        wait_done(3000, f0, ok);
        checks++;
        if (!ok || aw_cnt - a0 != 3) begin
            errors++; $display("FAIL ign_frame got done %b bursts %0d want 1 3", ok, aw_cnt - a0);
        end
        checks++;
        if (aw_log[(a0 + 1) % 256] !== 32'h3000_0080 ||
            aw_log[(a0 + 2) % 256] !== 32'h3000_0100) begin
            errors++;
            $display("FAIL ign_addrs got %h %h want 30000080 30000100",
                     aw_log[(a0 + 1) % 256], aw_log[(a0 + 2) % 256]);
        end
        a0 = aw_cnt;
        f0 = frm_cnt;
        start_frame(32'h4000_0000, 2'd0);
        wait_done(3000, f0, ok);
        checks++;
        if (!ok || aw_log[a0 % 256] !== 32'h4000_0000) begin
            errors++;
            $display("FAIL ign_new_base got done %b addr %h want 1 40000000", ok, aw_log[a0 % 256]);
        end
    endtask

    task automatic test_reset_mid_burst();
        int unsigned w0 = w_cnt, a0, p0, f0;
        bit ok;
        start_frame(32'h5000_0000, 2'd2);
        for (int i = 0; i < 500 && w_cnt - w0 < 7; i++) @(negedge ACLK);
        tick();
        ARST = 1'b1;
        tick();
        @(negedge ACLK);
        checks++;
        if ({AWVALID, WVALID, WLAST, BREADY, FIFORD, BUSY, FRMDONE, WRERR} !== 8'h00 ||
            AWADDR !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid got ctrl %b awaddr %h want 00000000 00000000",
                     {AWVALID, WVALID, WLAST, BREADY, FIFORD, BUSY, FRMDONE, WRERR}, AWADDR);
        end
        tick();
        ARST = 1'b0;
        tick();
        a0 = aw_cnt;
        p0 = pop_cnt;
        f0 = frm_cnt;
        start_frame(32'h6000_0000, 2'd2);
        wait_done(3000, f0, ok);
        checks++;
        if (!ok || aw_cnt - a0 != 4 || pop_cnt - p0 != 64) begin
            errors++;
            $display("FAIL rst_sxga got done %b bursts %0d pops %0d want 1 4 64",
                     ok, aw_cnt - a0, pop_cnt - p0);
        end
        checks++;
        if (aw_log[(a0 + 3) % 256] !== 32'h6000_0180) begin
            errors++;
            $display("FAIL rst_sxga_last got %h want 60000180", aw_log[(a0 + 3) % 256]);
        end
        checks++;
        if (bad_sum() != 0) begin
            errors++; $display("FAIL protocol_total got %0d want 0", bad_sum());
        end
    endtask

    initial begin
        test_reset();
        test_vga_frame();
        test_backpressure();
        test_fifo_threshold();
        test_bresp_err();
        test_capstart_ignored();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
